// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator car controller and its slot allocator.
package elevator_pkg;

    localparam int FLOOR_W = 3;
    localparam logic [FLOOR_W-1:0] MIN_FLOOR  = 3'd1;
    localparam logic [FLOOR_W-1:0] EMPTY_SLOT = 3'd0;

    localparam int HOLD_ALIGHT = 5;
    localparam int HOLD_BOARD  = 2;

    typedef enum logic [1:0] {
        IDLE,
        STOP,
        DOOR,
        MOVE
    } state_t;

    // A destination is boardable only if it names a real floor.
    function automatic logic dest_valid(input logic [FLOOR_W-1:0] dest, input int top_floor);
        return (dest != EMPTY_SLOT) && (int'(dest) <= top_floor);
    endfunction

endpackage

// File: rtl/car_slot_alloc.sv
// Combinational passenger slot allocator: clears arriving slots, then seats waiting
// passengers A then B into free slots (slot0 first) and reports who was seated.
module car_slot_alloc
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 7
) (
    input  logic [5:0] boarding,
    input  logic [5:0] hold_in,
    input  logic [5:0] wait_dest,
    output logic [5:0] boarding_next,
    output logic [1:0] served_mask
);

    logic [FLOOR_W-1:0] slot0;
    logic [FLOOR_W-1:0] slot1;

    always_comb begin
        slot0       = hold_in[3] ? EMPTY_SLOT : boarding[2:0];
        slot1       = hold_in[4] ? EMPTY_SLOT : boarding[5:3];
        served_mask = 2'b00;

        // Passenger A gets first pick, so B only sees what A left behind.
        if (hold_in[HOLD_BOARD] && hold_in[1] && dest_valid(wait_dest[5:3], NUM_FLOORS)) begin
            if (slot0 == EMPTY_SLOT) begin
                slot0          = wait_dest[5:3];
                served_mask[1] = 1'b1;
            end else if (slot1 == EMPTY_SLOT) begin
                slot1          = wait_dest[5:3];
                served_mask[1] = 1'b1;
            end
        end

        if (hold_in[HOLD_BOARD] && hold_in[0] && dest_valid(wait_dest[2:0], NUM_FLOORS)) begin
            if (slot0 == EMPTY_SLOT) begin
                slot0          = wait_dest[2:0];
                served_mask[0] = 1'b1;
            end else if (slot1 == EMPTY_SLOT) begin
                slot1          = wait_dest[2:0];
                served_mask[0] = 1'b1;
            end
        end

        boarding_next = {slot1, slot0};
    end

endmodule

// File: rtl/elevator_car.sv
// Per-car controller: owns floor, direction, passenger slots and door/travel timing,
// acting on the upstream turn/hold decision each time the car stops to evaluate.
module elevator_car
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 7,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3,
    parameter int TIMER_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               turn_in,
    input  logic [5:0]         hold_in,
    input  logic [5:0]         wait_dest,
    input  logic               req_pending,
    output logic [FLOOR_W-1:0] curr_floor,
    output logic               dir_up,
    output logic [5:0]         boarding,
    output logic               door_open,
    output logic               moving,
    output logic [1:0]         served
);

    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS);
    localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic               flip_done;

    logic               at_end;
    logic               has_work;
    logic [5:0]         boarding_next;
    logic [1:0]         served_mask;

    assign at_end   = dir_up ? (curr_floor == TOP_FLOOR) : (curr_floor == MIN_FLOOR);
    assign has_work = req_pending || (boarding != 6'd0);

    car_slot_alloc #(
        .NUM_FLOORS(NUM_FLOORS)
    ) u_alloc (
        .boarding     (boarding),
        .hold_in      (hold_in),
        .wait_dest    (wait_dest),
        .boarding_next(boarding_next),
        .served_mask  (served_mask)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            flip_done  <= 1'b0;
            curr_floor <= MIN_FLOOR;
            dir_up     <= 1'b1;
            boarding   <= 6'd0;
            door_open  <= 1'b0;
            moving     <= 1'b0;
            served     <= 2'b00;
        end else begin
            served <= 2'b00;
            case (state)
                IDLE: begin
                    if (has_work) state <= STOP;
                end
                STOP: begin
                    if (hold_in[HOLD_ALIGHT] || hold_in[HOLD_BOARD]) begin
                        state     <= DOOR;
                        door_open <= 1'b1;
                        boarding  <= boarding_next;
                        served    <= served_mask;
                        timer     <= DOOR_LOAD;
                        flip_done <= 1'b0;
                    end else if (at_end || turn_in) begin
                        // One direction flip per stop; a second dead end parks the car.
                        if (flip_done || !has_work) begin
                            state <= IDLE;
                        end else begin
                            dir_up    <= ~dir_up;
                            flip_done <= 1'b1;
                        end
                    end else begin
                        state     <= MOVE;
                        moving    <= 1'b1;
                        timer     <= TRAVEL_LOAD;
                        flip_done <= 1'b0;
                    end
                end
                DOOR: begin
                    if (timer == '0) begin
                        state     <= STOP;
                        door_open <= 1'b0;
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                MOVE: begin
                    if (timer == '0) begin
                        state  <= STOP;
                        moving <= 1'b0;
                        if (dir_up && curr_floor != TOP_FLOOR)
                            curr_floor <= curr_floor + FLOOR_W'(1);
                        else if (!dir_up && curr_floor != MIN_FLOOR)
                            curr_floor <= curr_floor - FLOOR_W'(1);
                    end else begin
                        timer <= timer - TIMER_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_car.sv
// Scoreboard bench for elevator_car: a stop-level reference model queues the expected
// per-cycle outputs, and an independent monitor compares them against the DUT.
module tb_elevator_car;

    localparam int NUM_FLOORS    = 7;
    localparam int TRAVEL_CYCLES = 4;
    localparam int DOOR_CYCLES   = 3;

    logic       clk;
    logic       rst_n;
    logic       turn_in;
    logic [5:0] hold_in;
    logic [5:0] wait_dest;
    logic       req_pending;
    logic [2:0] curr_floor;
    logic       dir_up;
    logic [5:0] boarding;
    logic       door_open;
    logic       moving;
    logic [1:0] served;

    elevator_car #(
        .NUM_FLOORS   (NUM_FLOORS),
        .TRAVEL_CYCLES(TRAVEL_CYCLES),
        .DOOR_CYCLES  (DOOR_CYCLES),
        .TIMER_W      (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .turn_in    (turn_in),
        .hold_in    (hold_in),
        .wait_dest  (wait_dest),
        .req_pending(req_pending),
        .curr_floor (curr_floor),
        .dir_up     (dir_up),
        .boarding   (boarding),
        .door_open  (door_open),
        .moving     (moving),
        .served     (served)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] floor;
        logic       dir;
        logic [5:0] board;
        logic       door;
        logic       mov;
        logic [1:0] srv;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    // Reference model state, tracked per stop rather than per cycle.
    logic [2:0] m_floor;
    logic       m_dir;
    logic [5:0] m_board;
    bit         m_flip;
    bit         m_idle;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Monitor: one queued expectation per clock while enabled.
    initial begin
        exp_t e;
        exp_t g;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty got=none want=entry");
                end else begin
                    e = exp_q.pop_front();
                    g = '{curr_floor, dir_up, boarding, door_open, moving, served};
                    if (g !== e) begin
                        errors++;
                        $display("FAIL cycle_outputs t=%0t got floor=%0d dir=%0d board=%o door=%0d mov=%0d srv=%b want floor=%0d dir=%0d board=%o door=%0d mov=%0d srv=%b",
                                 $time, g.floor, g.dir, g.board, g.door, g.mov, g.srv,
                                 e.floor, e.dir, e.board, e.door, e.mov, e.srv);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    // Called at a falling edge with inputs already set: queue the outputs expected after
    // the next rising edge, then advance to the following falling edge.
    task automatic cyc(input logic door, input logic mov, input logic [1:0] srv);
        exp_q.push_back('{m_floor, m_dir, m_board, door, mov, srv});
        @(negedge clk);
    endtask

    task automatic scramble();
        turn_in     = 1'($urandom);
        hold_in     = 6'($urandom);
        wait_dest   = 6'($urandom);
        req_pending = 1'($urandom);
    endtask

    task automatic model_alloc(input logic [5:0] b, input logic [5:0] h, input logic [5:0] wd,
                               output logic [5:0] nb, output logic [1:0] srv);
        logic [2:0] slots[2];
        logic [2:0] dst;
        slots[0] = h[3] ? 3'd0 : b[2:0];
        slots[1] = h[4] ? 3'd0 : b[5:3];
        srv = 2'b00;
        if (h[2]) begin
            for (int p = 1; p >= 0; p--) begin
                dst = (p == 1) ? wd[5:3] : wd[2:0];
                if (h[p] && dst >= 3'd1 && int'(dst) <= NUM_FLOORS) begin
                    for (int s = 0; s < 2; s++) begin
                        if (slots[s] == 3'd0) begin
                            slots[s] = dst;
                            srv[p]   = 1'b1;
                            break;
                        end
                    end
                end
            end
        end
        nb = {slots[1], slots[0]};
    endtask

    task automatic idle_cycle(input logic rq);
        scramble();
        req_pending = rq;
        if (rq || m_board != 6'd0) m_idle = 0;
        cyc(1'b0, 1'b0, 2'b00);
    endtask

    // One evaluation at a stop plus whatever door or travel time it triggers.
    task automatic stop_cycle(input logic t, input logic [5:0] h, input logic [5:0] wd, input logic rq);
        logic [5:0] nb;
        logic [1:0] srv;
        bit         edge_hit;
        turn_in     = t;
        hold_in     = h;
        wait_dest   = wd;
        req_pending = rq;
        edge_hit    = m_dir ? (m_floor == 3'(NUM_FLOORS)) : (m_floor == 3'd1);
        if (h[5] || h[2]) begin
            model_alloc(m_board, h, wd, nb, srv);
            $display("stop floor=%0d dir=%0d door board=%o->%o served=%b", m_floor, m_dir, m_board, nb, srv);
            m_board = nb;
            m_flip  = 0;
            for (int i = 0; i < DOOR_CYCLES; i++) begin
                if (i > 0) scramble();
                cyc(1'b1, 1'b0, (i == 0) ? srv : 2'b00);
            end
            scramble();
            cyc(1'b0, 1'b0, 2'b00);
        end else if (edge_hit || t) begin
            if (m_flip || (!rq && m_board == 6'd0)) begin
                $display("stop floor=%0d dir=%0d park", m_floor, m_dir);
                m_idle = 1;
            end else begin
                $display("stop floor=%0d dir=%0d reverse", m_floor, m_dir);
                m_dir  = !m_dir;
                m_flip = 1;
            end
            cyc(1'b0, 1'b0, 2'b00);
        end else begin
            $display("stop floor=%0d dir=%0d travel", m_floor, m_dir);
            m_flip = 0;
            for (int i = 0; i < TRAVEL_CYCLES; i++) begin
                if (i > 0) scramble();
                cyc(1'b0, 1'b1, 2'b00);
            end
            scramble();
            m_floor = m_dir ? m_floor + 3'd1 : m_floor - 3'd1;
            cyc(1'b0, 1'b0, 2'b00);
        end
    endtask

    task automatic model_reset();
        m_floor = 3'd1;
        m_dir   = 1'b1;
        m_board = 6'd0;
        m_flip  = 0;
        m_idle  = 1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_floor"}, 32'(curr_floor), 32'd1);
        chk({tag, "_dir"}, 32'(dir_up), 32'd1);
        chk({tag, "_boarding"}, 32'(boarding), 32'd0);
        chk({tag, "_door"}, 32'(door_open), 32'd0);
        chk({tag, "_moving"}, 32'(moving), 32'd0);
        chk({tag, "_served"}, 32'(served), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        turn_in     = 1'b0;
        hold_in     = 6'd0;
        wait_dest   = 6'd0;
        req_pending = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");

        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Quiet idle, then a trip up to floor 3.
        repeat (3) idle_cycle(1'b0);
        idle_cycle(1'b1);
        stop_cycle(1'b0, 6'd0, 6'd0, 1'b1);
        stop_cycle(1'b0, 6'd0, 6'd0, 1'b1);

        // Board two at floor 3, then alight plus board with one free slot at floor 5.
        stop_cycle(1'b0, 6'b000111, {3'd5, 3'd6}, 1'b1);
        stop_cycle(1'b0, 6'd0, 6'd0, 1'b1);
        stop_cycle(1'b0, 6'd0, 6'd0, 1'b1);
        stop_cycle(1'b0, 6'b101111, {3'd7, 3'd1}, 1'b1);

        // Run to the top floor, reverse there, then a turn held across both evaluations.
        stop_cycle(1'b0, 6'd0, 6'd0, 1'b1);
        stop_cycle(1'b0, 6'd0, 6'd0, 1'b1);
        stop_cycle(1'b0, 6'd0, 6'd0, 1'b1);
        stop_cycle(1'b0, 6'd0, 6'd0, 1'b1);
        stop_cycle(1'b1, 6'd0, 6'd0, 1'b1);
        stop_cycle(1'b1, 6'd0, 6'd0, 1'b1);

        // Start a move from floor 6 and reset partway through it.
        idle_cycle(1'b1);
        turn_in     = 1'b0;
        hold_in     = 6'd0;
        wait_dest   = 6'd0;
        req_pending = 1'b1;
        m_flip      = 0;
        cyc(1'b0, 1'b1, 2'b00);
        scramble();
        cyc(1'b0, 1'b1, 2'b00);
        mon_en = 1'b0;
        chk("premove_floor", 32'(curr_floor), 32'(m_floor));
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        mon_en = 1'b1;

        // Randomised stops checked against the model.
        for (int n = 0; n < 250; n++) begin
            if (m_idle) begin
                idle_cycle(1'($urandom_range(0, 3) != 0));
            end else begin
                logic [5:0] h;
                h = ($urandom_range(0, 9) < 4) ? 6'd0 : 6'($urandom);
                stop_cycle(1'($urandom_range(0, 3) == 0), h, 6'($urandom),
                           1'($urandom_range(0, 4) != 0));
            end
        end

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
